// File: rtl/id_ex_stage.sv
// id_ex_stage
// ----------------------------------------------------------------------------
// Decode/execute pipeline register in front of the 32-bit ALU. It decodes
// opcode/funct into a 3-bit ALU select and builds both operands. Operand A is
// always fwd(rs). Operand B is fwd(rt) or the sign-extended immediate.
// Forwarding comes from EX/MEM (highest priority) or MEM/WB. Register 0 is
// never forwarded. Everything is registered for the execute cycle.
// The stage also detects load-use hazards, inserts bubbles, honours stall and
// flush, and keeps a saturating count of inserted bubbles.
//
// Ports
//   clk, rst               rising-edge clock, synchronous active-high reset
//   stall                  hold every registered output
//   flush                  capture a bubble on the next edge
//   valid_in               decode-stage instruction is valid
//   opcode, funct, imm     instruction fields [31:26], [5:0], [15:0]
//   rs/rt/rd_addr          register specifiers
//   rs_data, rt_data       register-file read data
//   exmem_wr/rd/res        EX/MEM forwarding source
//   memwb_wr/rd/data       MEM/WB forwarding source
//   valid_out, alu_a, alu_b, alu_sel, dest,
//   reg_wr, mem_rd, mem_wr, branch   registered execute-stage bundle
//   illegal                one-cycle pulse: an unknown instruction became a bubble
//   load_use               combinational back-pressure to the decode stage
//   bubble_cnt             saturating count of load-use and illegal bubbles
//
// Handshake: valid_in qualifies the decode inputs. load_use acts as an
// active-high "not ready". While it is 1, the instruction is not consumed on
// this edge, and upstream must present the same inputs again next cycle.
// stall freezes this stage. The instruction presented during a stall is not
// consumed, so upstream must also hold its inputs.
// ----------------------------------------------------------------------------
module id_ex_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        valid_in,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic [4:0]  rs_addr,
  input  logic [4:0]  rt_addr,
  input  logic [4:0]  rd_addr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic [15:0] imm,
  input  logic        exmem_wr,
  input  logic [4:0]  exmem_rd,
  input  logic [31:0] exmem_res,
  input  logic        memwb_wr,
  input  logic [4:0]  memwb_rd,
  input  logic [31:0] memwb_data,
  output logic        valid_out,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_sel,
  output logic [4:0]  dest,
  output logic        reg_wr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        branch,
  output logic        illegal,
  output logic        load_use,
  output logic [15:0] bubble_cnt
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] SEL_AND = 3'b000;
  localparam logic [2:0] SEL_OR  = 3'b001;
  localparam logic [2:0] SEL_ADD = 3'b010;
  localparam logic [2:0] SEL_SUB = 3'b110;
  localparam logic [2:0] SEL_SLT = 3'b111;

  // Registered state
  logic        valid_q;
  logic [31:0] alu_a_q, alu_b_q;
  logic [2:0]  alu_sel_q;
  logic [4:0]  dest_q;
  logic        reg_wr_q, mem_rd_q, mem_wr_q, branch_q;
  logic        illegal_q;
  logic [15:0] bubble_cnt_q;

  // Decoded next-state values for a normal capture
  logic        legal_d;
  logic        uses_rt_d;
  logic        b_imm_d;
  logic [2:0]  alu_sel_d;
  logic [4:0]  dest_d;
  logic        reg_wr_d, mem_rd_d, mem_wr_d, branch_d;
  logic [31:0] fwd_rs, fwd_rt, sext_imm;
  logic [31:0] alu_a_d, alu_b_d;
  logic [15:0] bubble_cnt_d;

  // ---------------------------------------------------------------- decode
  always_comb begin
    legal_d   = 1'b0;
    uses_rt_d = 1'b0;
    b_imm_d   = 1'b0;
    alu_sel_d = SEL_AND;
    dest_d    = 5'd0;
    reg_wr_d  = 1'b0;
    mem_rd_d  = 1'b0;
    mem_wr_d  = 1'b0;
    branch_d  = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        uses_rt_d = 1'b1;
        reg_wr_d  = 1'b1;
        dest_d    = rd_addr;
        legal_d   = 1'b1;
        case (funct)
          FN_AND:  alu_sel_d = SEL_AND;
          FN_OR:   alu_sel_d = SEL_OR;
          FN_ADD:  alu_sel_d = SEL_ADD;
          FN_SUB:  alu_sel_d = SEL_SUB;
          FN_SLT:  alu_sel_d = SEL_SLT;
          default: legal_d   = 1'b0;
        endcase
      end
      OP_LW: begin
        legal_d   = 1'b1;
        alu_sel_d = SEL_ADD;
        b_imm_d   = 1'b1;
        mem_rd_d  = 1'b1;
        reg_wr_d  = 1'b1;
        dest_d    = rt_addr;
      end
      OP_SW: begin
        legal_d   = 1'b1;
        uses_rt_d = 1'b1;
        alu_sel_d = SEL_ADD;
        b_imm_d   = 1'b1;
        mem_wr_d  = 1'b1;
      end
      OP_BEQ: begin
        legal_d   = 1'b1;
        uses_rt_d = 1'b1;
        alu_sel_d = SEL_SUB;
        branch_d  = 1'b1;
      end
      OP_ADDI: begin
        legal_d   = 1'b1;
        alu_sel_d = SEL_ADD;
        b_imm_d   = 1'b1;
        reg_wr_d  = 1'b1;
        dest_d    = rt_addr;
      end
      default: legal_d = 1'b0;
    endcase
  end

  // ------------------------------------------------------------ forwarding
  // EX/MEM holds the younger result, so it is checked first.
  always_comb begin
    fwd_rs = rs_data;
    if (exmem_wr && exmem_rd == rs_addr && rs_addr != 5'd0)
      fwd_rs = exmem_res;
    else if (memwb_wr && memwb_rd == rs_addr && rs_addr != 5'd0)
      fwd_rs = memwb_data;

    fwd_rt = rt_data;
    if (exmem_wr && exmem_rd == rt_addr && rt_addr != 5'd0)
      fwd_rt = exmem_res;
    else if (memwb_wr && memwb_rd == rt_addr && rt_addr != 5'd0)
      fwd_rt = memwb_data;
  end

  assign sext_imm = {{16{imm[15]}}, imm};
  assign alu_a_d  = fwd_rs;
  assign alu_b_d  = b_imm_d ? sext_imm : fwd_rt;

  // ------------------------------------------------------ load-use hazard
  // A load sitting in this register cannot forward its data yet. One
  // bubble lets the loaded value reach a forwarding path.
  assign load_use = valid_in & valid_q & mem_rd_q & (dest_q != 5'd0) &
                    ((dest_q == rs_addr) | (uses_rt_d & (dest_q == rt_addr))) &
                    ~stall & ~flush;

  assign bubble_cnt_d = (bubble_cnt_q == 16'hFFFF) ? bubble_cnt_q
                                                   : bubble_cnt_q + 16'd1;

  // ---------------------------------------------------------- pipe register
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q      <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_sel_q    <= '0;
      dest_q       <= '0;
      reg_wr_q     <= 1'b0;
      mem_rd_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      branch_q     <= 1'b0;
      illegal_q    <= 1'b0;
      bubble_cnt_q <= '0;
    end else if (stall && !flush) begin
      // Hold everything, including the illegal pulse.
    end else if (flush || load_use || !valid_in || !legal_d) begin
      valid_q   <= 1'b0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_sel_q <= '0;
      dest_q    <= '0;
      reg_wr_q  <= 1'b0;
      mem_rd_q  <= 1'b0;
      mem_wr_q  <= 1'b0;
      branch_q  <= 1'b0;
      // Only an illegal instruction that actually reaches the capture
      // decision raises the pulse. Flush and load-use take precedence.
      illegal_q <= !flush && !load_use && valid_in && !legal_d;
      if (!flush && (load_use || (valid_in && !legal_d)))
        bubble_cnt_q <= bubble_cnt_d;
    end else begin
      valid_q   <= 1'b1;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_sel_q <= alu_sel_d;
      dest_q    <= dest_d;
      reg_wr_q  <= reg_wr_d;
      mem_rd_q  <= mem_rd_d;
      mem_wr_q  <= mem_wr_d;
      branch_q  <= branch_d;
      illegal_q <= 1'b0;
    end
  end

  assign valid_out  = valid_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_sel    = alu_sel_q;
  assign dest       = dest_q;
  assign reg_wr     = reg_wr_q;
  assign mem_rd     = mem_rd_q;
  assign mem_wr     = mem_wr_q;
  assign branch     = branch_q;
  assign illegal    = illegal_q;
  assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed testbench for id_ex_stage. Every expected value is hand-computed
// from the instruction semantics and written in as a constant.
module tb_id_ex_stage;

  // ------------------------------------------------------------------ clock
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stall, flush, valid_in;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs_addr, rt_addr, rd_addr;
  logic [31:0] rs_data, rt_data;
  logic [15:0] imm;
  logic        exmem_wr, memwb_wr;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_res, memwb_data;
  logic        valid_out, reg_wr, mem_rd, mem_wr, branch, illegal, load_use;
  logic [31:0] alu_a, alu_b;
  logic [2:0]  alu_sel;
  logic [4:0]  dest;
  logic [15:0] bubble_cnt;

  int vectors = 0;
  int miscompares = 0;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_in(valid_in),
    .opcode(opcode), .funct(funct), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rd_addr(rd_addr), .rs_data(rs_data), .rt_data(rt_data), .imm(imm),
    .exmem_wr(exmem_wr), .exmem_rd(exmem_rd), .exmem_res(exmem_res),
    .memwb_wr(memwb_wr), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
    .valid_out(valid_out), .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .dest(dest), .reg_wr(reg_wr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .branch(branch), .illegal(illegal), .load_use(load_use),
    .bubble_cnt(bubble_cnt)
  );

  // ----------------------------------------------------------- driver tasks
  // Advance one edge, then settle 1 time unit past it before any sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic instr(input logic [5:0] op, input logic [5:0] fn,
                       input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [31:0] rsd,
                       input logic [31:0] rtd, input logic [15:0] im);
    valid_in = 1'b1; opcode = op; funct = fn;
    rs_addr = rs; rt_addr = rt; rd_addr = rd;
    rs_data = rsd; rt_data = rtd; imm = im;
  endtask

  task automatic no_fwd();
    exmem_wr = 1'b0; exmem_rd = 5'd0; exmem_res = 32'd0;
    memwb_wr = 1'b0; memwb_rd = 5'd0; memwb_data = 32'd0;
  endtask

  // --------------------------------------------------------------- sequence
  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    instr(6'd0, 6'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 16'd0);
    valid_in = 1'b0;
    no_fwd();
    step(); step();
    rst = 1'b0;
    chk("rst_valid", {31'd0, valid_out}, 32'd0);
    chk("rst_cnt", {16'd0, bubble_cnt}, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);

    // ADD r3 = r1 + r2
    instr(6'b000000, 6'b100000, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 16'd0);
    step();
    chk("add_valid", {31'd0, valid_out}, 32'd1);
    chk("add_sel", {29'd0, alu_sel}, 32'd2);
    chk("add_a", alu_a, 32'd5);
    chk("add_b", alu_b, 32'd7);
    chk("add_dest", {27'd0, dest}, 32'd3);
    chk("add_regwr", {31'd0, reg_wr}, 32'd1);
    chk("add_memrd", {31'd0, mem_rd}, 32'd0);

    // AND: both sources target rs=4; EX/MEM must win
    instr(6'b000000, 6'b100100, 5'd4, 5'd5, 5'd6, 32'hDEAD, 32'd9, 16'd0);
    exmem_wr = 1'b1; exmem_rd = 5'd4; exmem_res = 32'h11;
    memwb_wr = 1'b1; memwb_rd = 5'd4; memwb_data = 32'h22;
    step();
    chk("fwd_both_a", alu_a, 32'h11);
    chk("fwd_both_b", alu_b, 32'd9);
    chk("and_sel", {29'd0, alu_sel}, 32'd0);

    // OR: rs from EX/MEM, rt from MEM/WB
    instr(6'b000000, 6'b100101, 5'd4, 5'd6, 5'd7, 32'd1, 32'd2, 16'd0);
    memwb_rd = 5'd6;
    step();
    chk("fwd_ex_a", alu_a, 32'h11);
    chk("fwd_wb_b", alu_b, 32'h22);
    chk("or_sel", {29'd0, alu_sel}, 32'd1);

    // SLT with register 0: never forwarded
    instr(6'b000000, 6'b101010, 5'd0, 5'd0, 5'd7, 32'h55, 32'h66, 16'd0);
    exmem_rd = 5'd0; memwb_rd = 5'd0;
    step();
    chk("r0_a", alu_a, 32'h55);
    chk("r0_b", alu_b, 32'h66);
    chk("slt_sel", {29'd0, alu_sel}, 32'd7);
    no_fwd();

    // lw r8, 4(r1)
    instr(6'b100011, 6'd0, 5'd1, 5'd8, 5'd0, 32'h100, 32'd0, 16'h0004);
    step();
    chk("lw_memrd", {31'd0, mem_rd}, 32'd1);
    chk("lw_dest", {27'd0, dest}, 32'd8);
    chk("lw_b", alu_b, 32'd4);
    chk("lw_a", alu_a, 32'h100);

    // SUB r10 = r9 - r8 depends on the load
    instr(6'b000000, 6'b100010, 5'd9, 5'd8, 5'd10, 32'd3, 32'd0, 16'd0);
    #1;
    chk("lu_comb", {31'd0, load_use}, 32'd1);
    step();
    chk("lu_bubble", {31'd0, valid_out}, 32'd0);
    chk("lu_cnt", {16'd0, bubble_cnt}, 32'd1);
    chk("lu_drop", {31'd0, load_use}, 32'd0);
    memwb_wr = 1'b1; memwb_rd = 5'd8; memwb_data = 32'hAB;
    step();
    chk("held_valid", {31'd0, valid_out}, 32'd1);
    chk("held_sel", {29'd0, alu_sel}, 32'd6);
    chk("held_b", alu_b, 32'hAB);
    chk("held_dest", {27'd0, dest}, 32'd10);
    no_fwd();

    // sw with negative offset
    instr(6'b101011, 6'd0, 5'd2, 5'd3, 5'd0, 32'h40, 32'd1, 16'h8000);
    step();
    chk("sw_b", alu_b, 32'hFFFF8000);
    chk("sw_ctl", {28'd0, mem_wr, reg_wr, mem_rd, branch}, 32'b1000);
    chk("sw_dest", {27'd0, dest}, 32'd0);

    // addi then a 3-cycle stall with changing inputs
    instr(6'b001000, 6'd0, 5'd1, 5'd12, 5'd0, 32'h10, 32'd0, 16'hFFFE);
    step();
    chk("addi_b", alu_b, 32'hFFFFFFFE);
    chk("addi_dest", {27'd0, dest}, 32'd12);
    stall = 1'b1;
    instr(6'b000100, 6'd0, 5'd3, 5'd4, 5'd0, 32'd1, 32'd2, 16'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_b", alu_b, 32'hFFFFFFFE);
      chk("stall_a", alu_a, 32'h10);
      chk("stall_dest", {27'd0, dest}, 32'd12);
      chk("stall_valid", {31'd0, valid_out}, 32'd1);
    end
    stall = 1'b0;

    // beq
    step();
    chk("beq_ctl", {28'd0, mem_wr, reg_wr, mem_rd, branch}, 32'b0001);
    chk("beq_sel", {29'd0, alu_sel}, 32'd6);

    // Illegal opcode, then stall holds the pulse, then flush+stall
    instr(6'b111111, 6'd0, 5'd1, 5'd2, 5'd3, 32'd1, 32'd2, 16'd0);
    step();
    chk("ill_pulse", {31'd0, illegal}, 32'd1);
    chk("ill_valid", {31'd0, valid_out}, 32'd0);
    chk("ill_cnt", {16'd0, bubble_cnt}, 32'd2);
    // R-type with an unknown funct is illegal too
    instr(6'b000000, 6'b000000, 5'd1, 5'd2, 5'd3, 32'd1, 32'd2, 16'd0);
    step();
    chk("ill_fn", {31'd0, illegal}, 32'd1);
    chk("ill_fn_cnt", {16'd0, bubble_cnt}, 32'd3);
    stall = 1'b1;
    step();
    chk("ill_hold", {31'd0, illegal}, 32'd1);
    chk("ill_hold_cnt", {16'd0, bubble_cnt}, 32'd3);
    flush = 1'b1;
    instr(6'b000000, 6'b100000, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 16'd0);
    step();
    chk("flush_valid", {31'd0, valid_out}, 32'd0);
    chk("flush_ill", {31'd0, illegal}, 32'd0);
    chk("flush_cnt", {16'd0, bubble_cnt}, 32'd3);
    flush = 1'b0; stall = 1'b0;

    // Load-use is suppressed while stalling
    instr(6'b100011, 6'd0, 5'd1, 5'd8, 5'd0, 32'h100, 32'd0, 16'h0004);
    step();
    instr(6'b000000, 6'b100000, 5'd8, 5'd2, 5'd3, 32'd5, 32'd7, 16'd0);
    stall = 1'b1;
    #1;
    chk("lu_stall", {31'd0, load_use}, 32'd0);
    stall = 1'b0;
    #1;
    chk("lu_rs", {31'd0, load_use}, 32'd1);

    // Reset mid-hazard and mid-stall wins
    stall = 1'b1; rst = 1'b1;
    step();
    rst = 1'b0; stall = 1'b0; valid_in = 1'b0;
    chk("mrst_valid", {31'd0, valid_out}, 32'd0);
    chk("mrst_a", alu_a, 32'd0);
    chk("mrst_ctl", {28'd0, mem_wr, reg_wr, mem_rd, branch}, 32'd0);
    chk("mrst_cnt", {16'd0, bubble_cnt}, 32'd0);

    // Saturation: 65535 illegal bubbles, then one more
    instr(6'b111111, 6'd0, 5'd1, 5'd2, 5'd3, 32'd1, 32'd2, 16'd0);
    repeat (65535) step();
    chk("sat_reach", {16'd0, bubble_cnt}, 32'hFFFF);
    step();
    chk("sat_hold", {16'd0, bubble_cnt}, 32'hFFFF);
    valid_in = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
